// File: rtl/wb_lsu_adapter_if.sv
// Bus bundle between the CPU Wishbone port, the load/store adapter and the word-organised BRAM.
// The slave modport is the adapter's view; master is the CPU plus memory side.
interface wb_lsu_adapter_if;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic [2:0]  i_wb_sel;
    logic [31:0] o_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic        o_wb_err;
    logic        o_mem_stb;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic [3:0]  o_mem_sel;
    logic [31:0] i_mem_data;
    logic        i_mem_ack;
    logic        i_mem_stall;

    modport slave (
        input  i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_data, o_wb_ack, o_wb_stall, o_wb_err,
        output o_mem_stb, o_mem_we, o_mem_addr, o_mem_data, o_mem_sel,
        input  i_mem_data, i_mem_ack, i_mem_stall
    );

    modport master (
        output i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_data, o_wb_ack, o_wb_stall, o_wb_err,
        input  o_mem_stb, o_mem_we, o_mem_addr, o_mem_data, o_mem_sel,
        output i_mem_data, i_mem_ack, i_mem_stall
    );
endinterface

// File: rtl/wb_lsu_adapter.sv
// Byte-addressed RV32 load/store adapter onto a 32-bit word memory: lane shifting,
// load extension and two-beat splitting of accesses that straddle a word boundary.
module wb_lsu_adapter #(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter logic [31:0] ERR_DATA         = 32'h0000_0000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    wb_lsu_adapter_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BEAT0 = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_BEAT1 = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]  state;
    logic        err_q;
    logic        we_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [7:0]  mask_q;
    logic [63:0] sdata_q;
    logic [29:0] wa_q;
    logic [31:0] w0_q;
    logic [31:0] w1_q;

    logic [3:0]  base;
    logic [7:0]  mask_n;
    logic [63:0] sdata_n;
    logic        misaligned;
    logic        illegal;
    logic        accept;

    // Extract the addressed bytes from the two captured words and extend per funct3.
    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [63:0] words,
                                                input logic [1:0] off);
        logic [31:0] r;
        r = 32'(words >> {off, 3'b000});
        case (f3)
            3'b000:  return {{24{r[7]}}, r[7:0]};
            3'b001:  return {{16{r[15]}}, r[15:0]};
            3'b100:  return {24'd0, r[7:0]};
            3'b101:  return {16'd0, r[15:0]};
            default: return r;
        endcase
    endfunction

    always_comb begin
        case (bus.i_wb_sel[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        mask_n     = {4'b0000, base} << bus.i_wb_addr[1:0];
        sdata_n    = {32'd0, bus.i_wb_data} << {bus.i_wb_addr[1:0], 3'b000};
        misaligned = ((bus.i_wb_sel[1:0] == 2'b01) && bus.i_wb_addr[0]) ||
                     ((bus.i_wb_sel[1:0] == 2'b10) && (bus.i_wb_addr[1:0] != 2'b00));
        illegal    = (bus.i_wb_sel == 3'b011) || (bus.i_wb_sel == 3'b110) ||
                     (bus.i_wb_sel == 3'b111) || (bus.i_wb_we && bus.i_wb_sel[2]) ||
                     (!ALLOW_MISALIGNED && misaligned);
        accept     = (state == S_IDLE) && bus.i_wb_stb;
    end

    // Control: reset abandons any transfer, so a late memory ack lands in IDLE and is dropped.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    err_q <= illegal;
                    state <= illegal ? S_RESP : S_BEAT0;
                end
                S_BEAT0: if (!bus.i_mem_stall) state <= S_WAIT0;
                S_WAIT0: if (bus.i_mem_ack) state <= (mask_q[7:4] != 4'd0) ? S_BEAT1 : S_RESP;
                S_BEAT1: if (!bus.i_mem_stall) state <= S_WAIT1;
                S_WAIT1: if (bus.i_mem_ack) state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request and read-data holding registers carry no reset; every output is gated by state.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            we_q    <= bus.i_wb_we;
            off_q   <= bus.i_wb_addr[1:0];
            f3_q    <= bus.i_wb_sel;
            mask_q  <= mask_n;
            sdata_q <= sdata_n;
            wa_q    <= bus.i_wb_addr[31:2];
            w1_q    <= 32'd0;
        end
        if ((state == S_WAIT0) && bus.i_mem_ack) w0_q <= bus.i_mem_data;
        if ((state == S_WAIT1) && bus.i_mem_ack) w1_q <= bus.i_mem_data;
    end

    always_comb begin
        bus.o_mem_stb  = 1'b0;
        bus.o_mem_we   = 1'b0;
        bus.o_mem_addr = 32'd0;
        bus.o_mem_data = 32'd0;
        bus.o_mem_sel  = 4'd0;
        if (state == S_BEAT0) begin
            bus.o_mem_stb  = !bus.i_mem_stall;
            bus.o_mem_we   = we_q;
            bus.o_mem_addr = {2'b00, wa_q};
            bus.o_mem_data = sdata_q[31:0];
            bus.o_mem_sel  = mask_q[3:0];
        end else if (state == S_BEAT1) begin
            bus.o_mem_stb  = !bus.i_mem_stall;
            bus.o_mem_we   = we_q;
            bus.o_mem_addr = {2'b00, wa_q + 30'd1};
            bus.o_mem_data = sdata_q[63:32];
            bus.o_mem_sel  = mask_q[7:4];
        end

        bus.o_wb_ack   = (state == S_RESP);
        bus.o_wb_err   = (state == S_RESP) && err_q;
        bus.o_wb_stall = (state != S_IDLE);
        bus.o_wb_data  = 32'd0;
        if (state == S_RESP) begin
            if (err_q)      bus.o_wb_data = ERR_DATA;
            else if (!we_q) bus.o_wb_data = load_extend(f3_q, {w1_q, w0_q}, off_q);
        end
    end

endmodule
